// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_pkg
// Purpose  : Shared types and constants for the serial 16-bit adder.
// Revision : 1.0  initial release
// ============================================================================
package serial_add_pkg;

  // Bits consumed per RUN cycle by the adder slice
  localparam int SLICE_W = 2;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/add_slice2.sv
`default_nettype none
// ============================================================================
// Module   : add_slice2
// Purpose  : Combinational 2-bit adder slice with carry in / carry out.
// Revision : 1.0  initial release
// ============================================================================
module add_slice2
  import serial_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               c
);

  // Extend by one bit so the carry lands in the MSB of the result
  assign {c, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, ci};

endmodule
`default_nettype wire

// File: rtl/serial_add16.sv
`default_nettype none
// ============================================================================
// Module   : serial_add16
// Purpose  : Multi-cycle adder. Operands are accepted over a valid/ready
//            handshake, walked LSB-first through a 2-bit slice with a
//            registered carry, and the result is offered on an output
//            handshake.
// Options  : SERIAL_ADD_SUB_EN - adds the 'sub' input; sub=1 computes a-b.
// Revision : 1.0  initial release
// ============================================================================
module serial_add16
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int c_n     = WIDTH / SLICE_W;
  localparam int c_cnt_w = (c_n > 1) ? $clog2(c_n) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n - 1);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_count;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic [SLICE_W-1:0] w_s;
  logic               w_c;
  logic [WIDTH-1:0]   w_sum_next;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_b_load;
  logic               w_cin_load;

  // Subtraction reuses the adder: a + ~b + 1
`ifdef SERIAL_ADD_SUB_EN
  assign w_b_load   = sub ? ~b : b;
  assign w_cin_load = sub ? 1'b1 : cin;
`else
  assign w_b_load   = b;
  assign w_cin_load = cin;
`endif

  // Handshake outputs come only from registered state (plus reset gating)
  assign in_ready  = (r_state == ST_IDLE) && !rst;
  assign out_valid = (r_state == ST_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_count == c_last);

  add_slice2 u_slice (
    .a  (r_a_sh[SLICE_W-1:0]),
    .b  (r_b_sh[SLICE_W-1:0]),
    .ci (r_carry),
    .s  (w_s),
    .c  (w_c)
  );

  // Partial-result accumulator: new slice bits enter at the top, so after
  // c_n shifts the full sum is assembled LSB-first. Only the upper bits need
  // storage; the newest slice goes straight into the final result.
  generate
    if (WIDTH > SLICE_W) begin : g_sum_sh
      logic [WIDTH-SLICE_W-1:0] r_sum_sh;

      // Shift one completed slice in per RUN cycle
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sum_sh <= '0;
        end else if (r_state == ST_RUN) begin
          r_sum_sh <= w_sum_next[WIDTH-1:SLICE_W];
        end
      end

      assign w_sum_next = {w_s, r_sum_sh};
    end else begin : g_sum_direct
      assign w_sum_next = w_s;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last)    w_state_next = ST_DONE;
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  // Operand capture, slice stepping, and result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= w_b_load;
            r_carry <= w_cin_load;
            r_count <= '0;
          end
        end
        ST_RUN: begin
          r_a_sh  <= r_a_sh >> SLICE_W;
          r_b_sh  <= r_b_sh >> SLICE_W;
          r_carry <= w_c;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_sum  <= w_sum_next;
            r_cout <= w_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add16.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add16
// Purpose  : Randomized self-checking bench for serial_add16 against an
//            arithmetic reference (a + b + cin, or a - b when subtracting).
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_add16;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks = 0;
  int errors = 0;

  serial_add16 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction: accept, wait for result, hold for 'hold' cycles of
  // backpressure, then consume. Inputs are churned while busy if requested.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tcin, input logic tsub, input int hold,
                        input bit churn);
    logic [WIDTH:0] exp;
    int  j;
    bit  seen;
    bit  busy_ok;
`ifdef SERIAL_ADD_SUB_EN
    if (tsub) exp = {1'b0, ta} + {1'b0, ~tb_v} + (WIDTH+1)'(1);
    else      exp = {1'b0, ta} + {1'b0, tb_v} + (WIDTH+1)'(tcin);
`else
    exp = {1'b0, ta} + {1'b0, tb_v} + (WIDTH+1)'(tcin);
    if (tsub) exp = exp;
`endif
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a = ta; b = tb_v; cin = tcin;
`ifdef SERIAL_ADD_SUB_EN
    sub = tsub;
`endif
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    j = 0; seen = 0; busy_ok = 1;
    while (j <= N + 4) begin
      if (out_valid) begin seen = 1; break; end
      if (in_ready) busy_ok = 0;
      if (churn) begin
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      end
      @(negedge clk);
      j++;
    end
    check("in_ready_busy", busy_ok, 1);
    if (!seen) begin
      check("out_valid_timeout", 0, 1);
    end else begin
      check("latency", j, N);
      check("sum", sum, exp[WIDTH-1:0]);
      check("cout", cout, exp[WIDTH]);
      for (int h = 0; h < hold; h++) begin
        if (churn) begin a = WIDTH'($urandom); b = WIDTH'($urandom); end
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_sum", sum, exp[WIDTH-1:0]);
        check("hold_ready", in_ready, 0);
      end
      // Offer a new operand in the consume cycle: it must not be taken.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("release_valid", out_valid, 0);
      check("release_ready", in_ready, 1);
    end
  endtask

  initial begin
    bit quiet;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);

    // Directed cases
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 0);
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 0, 0);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 5, 0);
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1, 1);

    // Abort mid-RUN at count 3
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_ready_in_rst", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", in_ready, 1);
    quiet = 1;
    repeat (N + 4) begin
      @(negedge clk);
      if (out_valid) quiet = 0;
    end
    check("abort_no_result", quiet, 1);
    run_op(16'h0002, 16'h0003, 1'b0, 1'b0, 0, 0);

`ifdef SERIAL_ADD_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 0);
`endif

    // Randomized operations with churn and random backpressure
    for (int i = 0; i < 16; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
